// File: rtl/regfile_pkg.sv
// Shared defaults and packed types for the register file with issue scoreboard.
package regfile_pkg;
  localparam int DEF_WIDTH     = 32;
  localparam int DEF_DEPTH     = 32;
  localparam int DEF_ADDR_BITS = 5;
  localparam int DEF_NRD       = 2;
  localparam int DEF_NWR       = 1;
  localparam int DEF_ZERO_R0   = 1;

  typedef logic [DEF_ADDR_BITS-1:0] addr_t;
  typedef logic [DEF_WIDTH-1:0]     data_t;
  typedef logic [DEF_DEPTH-1:0]     busy_t;
endpackage

// File: rtl/regfile_bypass_mux.sv
// One read port's write-forwarding select: the highest-index matching write wins.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int NWR       = DEF_NWR
) (
  input  logic [ADDR_BITS-1:0]          rd_addr,
  input  logic [WIDTH-1:0]              reg_word,
  input  logic [NWR-1:0]                wr_ok,
  input  logic [NWR-1:0][ADDR_BITS-1:0] wr_addr,
  input  logic [NWR-1:0][WIDTH-1:0]     wr_data,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          wr_hit
);
  always_comb begin
    rd_data = reg_word;
    wr_hit  = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      if (wr_ok[p] && (wr_addr[p] == rd_addr)) begin
        rd_data = wr_data[p];
        wr_hit  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write bypass and a per-register busy scoreboard.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int NRD       = DEF_NRD,
  parameter int NWR       = DEF_NWR,
  parameter int ZERO_R0   = DEF_ZERO_R0
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NRD-1:0][ADDR_BITS-1:0] rd_addr,
  output logic [NRD-1:0][WIDTH-1:0]     rd_data,
  output logic [NRD-1:0]                rd_busy,
  input  logic [NWR-1:0]                wr_en,
  input  logic [NWR-1:0][ADDR_BITS-1:0] wr_addr,
  input  logic [NWR-1:0][WIDTH-1:0]     wr_data,
  input  logic                          iss_en,
  input  logic [ADDR_BITS-1:0]          iss_addr,
  output logic [ADDR_BITS:0]            busy_cnt
);
  localparam logic [ADDR_BITS:0] DEPTH_L = (ADDR_BITS+1)'(DEPTH);

  // Addresses that name a real, writable register.
  function automatic logic addr_ok(input logic [ADDR_BITS-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  logic [WIDTH-1:0]   regs_reg  [DEPTH];
  logic [WIDTH-1:0]   regs_next [DEPTH];
  logic [DEPTH-1:0]   busy_reg, busy_next;
  logic [ADDR_BITS:0] cnt_reg, cnt_next;
  logic [NWR-1:0]     wr_ok;
  logic               iss_ok;

  // Gating with RST keeps reset-time strobes from leaking through the bypass.
  for (genvar gi = 0; gi < NWR; gi++) begin : g_wr_ok
    assign wr_ok[gi] = wr_en[gi] & RST & addr_ok(wr_addr[gi]);
  end
  assign iss_ok = iss_en & RST & addr_ok(iss_addr);

  always_comb begin
    busy_next = busy_reg;
    cnt_next  = '0;
    for (int a = 0; a < DEPTH; a++) begin
      regs_next[a] = regs_reg[a];
      for (int p = 0; p < NWR; p++) begin
        if (wr_ok[p] && (wr_addr[p] == ADDR_BITS'(a))) begin
          regs_next[a] = wr_data[p];
          busy_next[a] = 1'b0;
        end
      end
      // A new producer issued alongside the writeback keeps the register busy.
      if (iss_ok && (iss_addr == ADDR_BITS'(a))) begin
        busy_next[a] = 1'b1;
      end
    end
    for (int a = 0; a < DEPTH; a++) begin
      cnt_next = cnt_next + (ADDR_BITS+1)'(busy_next[a]);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int a = 0; a < DEPTH; a++) begin
        regs_reg[a] <= '0;
      end
      busy_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        regs_reg[a] <= regs_next[a];
      end
      busy_reg <= busy_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign busy_cnt = cnt_reg;

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic             rd_ok;
    logic [WIDTH-1:0] reg_word;
    logic             busy_bit;
    logic             wr_hit;

    assign rd_ok    = addr_ok(rd_addr[gi]);
    assign reg_word = rd_ok ? regs_reg[rd_addr[gi]] : '0;
    assign busy_bit = rd_ok ? busy_reg[rd_addr[gi]] : 1'b0;

    regfile_bypass_mux #(
      .WIDTH     (WIDTH),
      .ADDR_BITS (ADDR_BITS),
      .NWR       (NWR)
    ) u_bypass (
      .rd_addr  (rd_addr[gi]),
      .reg_word (reg_word),
      .wr_ok    (wr_ok),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data[gi]),
      .wr_hit   (wr_hit)
    );

    assign rd_busy[gi] = busy_bit & ~wr_hit;
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard with a behavioural reference model.
module tb_regfile_scoreboard;
  localparam int W  = 32;
  localparam int D  = 24;
  localparam int AB = 5;

  logic                   CLK = 1'b0;
  logic                   RST = 1'b0;
  logic [1:0][AB-1:0]     rd_addr;
  logic [1:0][W-1:0]      rd_data;
  logic [1:0]             rd_busy;
  logic [1:0]             wr_en;
  logic [1:0][AB-1:0]     wr_addr;
  logic [1:0][W-1:0]      wr_data;
  logic                   iss_en;
  logic [AB-1:0]          iss_addr;
  logic [AB:0]            busy_cnt;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(
    .WIDTH(W), .DEPTH(D), .ADDR_BITS(AB), .NRD(2), .NWR(2), .ZERO_R0(1)
  ) dut (
    .CLK(CLK), .RST(RST), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference state: register contents and busy flags as the rules define them.
  logic [W-1:0] m_regs [32];
  logic [31:0]  m_busy;

  function automatic bit m_valid(logic [AB-1:0] a);
    return (a != 0) && (int'(a) < D);
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= '0;
      m_busy <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p] && m_valid(wr_addr[p])) begin
          m_regs[wr_addr[p]] <= wr_data[p];
          m_busy[wr_addr[p]] <= 1'b0;
        end
      end
      if (iss_en && m_valid(iss_addr)) m_busy[iss_addr] <= 1'b1;
    end
  end

  function automatic logic [W-1:0] exp_data(logic [AB-1:0] a);
    logic [W-1:0] v;
    if (!RST || !m_valid(a)) return '0;
    v = m_regs[a];
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && wr_addr[p] == a) v = wr_data[p];
    return v;
  endfunction

  function automatic logic exp_busy(logic [AB-1:0] a);
    if (!RST || !m_valid(a)) return 1'b0;
    for (int p = 0; p < 2; p++)
      if (wr_en[p] && wr_addr[p] == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("check %s: %h", name, act);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle between edges.
  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rd_data[k] !== exp_data(rd_addr[k])) begin
        errors++;
        $display("FAIL model rd_data[%0d] t=%0t: got %h expected %h", k, $time, rd_data[k], exp_data(rd_addr[k]));
      end
      checks++;
      if (rd_busy[k] !== exp_busy(rd_addr[k])) begin
        errors++;
        $display("FAIL model rd_busy[%0d] t=%0t: got %b expected %b", k, $time, rd_busy[k], exp_busy(rd_addr[k]));
      end
    end
    checks++;
    if (busy_cnt !== (AB+1)'($countones(m_busy))) begin
      errors++;
      $display("FAIL model busy_cnt t=%0t: got %0d expected %0d", $time, busy_cnt, $countones(m_busy));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic wr(input int p, input logic [AB-1:0] a, input logic [W-1:0] d);
    wr_en[p] = 1'b1; wr_addr[p] = a; wr_data[p] = d;
  endtask

  task automatic iss(input logic [AB-1:0] a);
    iss_en = 1'b1; iss_addr = a;
  endtask

  initial begin
    idle();
    rd_addr = '{5'd5, 5'd5};
    // Strobes during reset must have no visible effect.
    wr(0, 5'd5, 32'h77); iss(5'd5);
    step(); step(); #1;
    chk("reset_rd_data0", rd_data[0], 32'h0);
    chk("reset_rd_busy", 32'(rd_busy), 32'h0);
    chk("reset_busy_cnt", 32'(busy_cnt), 32'h0);
    step(); idle(); RST = 1'b1;

    step(); wr(0, 5'd5, 32'hDEADBEEF); rd_addr = '{5'd1, 5'd2};
    step(); idle(); rd_addr = '{5'd5, 5'd5}; #1;
    chk("r5_port0", rd_data[0], 32'hDEADBEEF);
    chk("r5_port1", rd_data[1], 32'hDEADBEEF);

    step(); wr(0, 5'd7, 32'h1234); rd_addr[0] = 5'd7; #1;
    chk("r7_bypass", rd_data[0], 32'h1234);

    step(); idle(); wr(0, 5'd3, 32'hAAAA); wr(1, 5'd3, 32'h5555); rd_addr[0] = 5'd3; #1;
    chk("r3_bypass_prio", rd_data[0], 32'h5555);
    step(); idle(); rd_addr = '{5'd7, 5'd3}; #1;
    chk("r3_stored_prio", rd_data[0], 32'h5555);
    chk("r7_stored", rd_data[1], 32'h1234);

    step(); wr(0, 5'd0, 32'hFFFF); rd_addr[0] = 5'd0; #1;
    chk("r0_no_bypass", rd_data[0], 32'h0);
    step(); idle(); iss(5'd0); #1;
    chk("r0_read", rd_data[0], 32'h0);
    step(); idle(); #1;
    chk("r0_not_busy", 32'(busy_cnt), 32'h0);

    step(); wr(0, 5'd30, 32'hABCD); iss(5'd30); rd_addr[0] = 5'd30; #1;
    chk("oob_no_bypass", rd_data[0], 32'h0);
    step(); idle(); wr(1, 5'd23, 32'h2323); #1;
    chk("oob_not_busy", 32'(busy_cnt), 32'h0);
    step(); idle(); rd_addr[0] = 5'd23; #1;
    chk("r23_last", rd_data[0], 32'h2323);

    step(); iss(5'd4); rd_addr[0] = 5'd4; #1;
    chk("r4_issue_cycle", 32'(rd_busy[0]), 32'h0);
    step(); idle(); #1;
    chk("r4_busy_c1", 32'(rd_busy[0]), 32'h1);
    chk("r4_cnt_c1", 32'(busy_cnt), 32'h1);
    step(); #1;
    chk("r4_busy_c2", 32'(rd_busy[0]), 32'h1);
    step(); wr(0, 5'd4, 32'h44); #1;
    chk("r4_wb_ready", 32'(rd_busy[0]), 32'h0);
    chk("r4_wb_data", rd_data[0], 32'h44);
    chk("r4_cnt_wb", 32'(busy_cnt), 32'h1);
    step(); idle(); #1;
    chk("r4_cnt_clear", 32'(busy_cnt), 32'h0);

    step(); iss(5'd9); wr(0, 5'd9, 32'h99); rd_addr[0] = 5'd9; #1;
    chk("r9_same_cycle_ready", 32'(rd_busy[0]), 32'h0);
    step(); idle(); iss(5'd10); #1;
    chk("r9_still_busy", 32'(rd_busy[0]), 32'h1);
    chk("r9_data", rd_data[0], 32'h99);
    chk("r9_cnt", 32'(busy_cnt), 32'h1);
    step(); idle(); iss(5'd9); #1;
    chk("r9_r10_cnt", 32'(busy_cnt), 32'h2);
    step(); idle(); #1;
    chk("reissue_cnt", 32'(busy_cnt), 32'h2);

    step(); wr(0, 5'd9, 32'h1); RST = 1'b0; #1;
    chk("midrst_data", rd_data[0], 32'h0);
    chk("midrst_busy", 32'(rd_busy[0]), 32'h0);
    chk("midrst_cnt", 32'(busy_cnt), 32'h0);
    step(); step(); idle(); RST = 1'b1;
    step(); rd_addr = '{5'd5, 5'd3}; #1;
    chk("post_rst_r3", rd_data[0], 32'h0);
    chk("post_rst_r5", rd_data[1], 32'h0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
